riscv_cache: RTL and testbench

- Unified instruction/data memory ("cache") for the RV32IM core, built as one word array.
- Loaded over an I/O write port before the program runs.
- During execution it serves combinational instruction fetch (PC) and byte/half/word loads and stores with sign/zero extension.
- A valid flag gates use: set when loading completes, cleared when the program finishes.

---
 rtl/riscv_cache_pkg.sv | 29 ++
 rtl/riscv_cache_load_align.sv | 39 +++
 rtl/riscv_cache.sv | 140 ++++++++++++++
 tb/tb_riscv_cache.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_cache_pkg.sv
// Shared definitions for the unified RV32IM instruction/data memory.
// Access-size codes, the valid-flag state type and the store byte-enable helper.
package riscv_cache_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Half period of the simulation clock.
    localparam int PERIOD_HALF = 5;

    typedef enum logic {
        ST_INVALID = 1'b0,
        ST_VALID   = 1'b1
    } cache_state_e;

    // Lane enables for a store; size code 2'b11 behaves as a word.
    function automatic logic [3:0] store_byte_en(input logic [1:0] size,
                                                 input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << off;
            SIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/riscv_cache_load_align.sv
// Load alignment: picks the addressed byte/halfword out of a memory word
// and sign- or zero-extends it to 32 bits.
module riscv_cache_load_align
    import riscv_cache_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (off_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        // Halfword selection ignores off_i[0]: misaligned halves use their aligned pair.
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        data_o = word_i;
        case (size_i)
            SIZE_BYTE: data_o = unsigned_i ? {24'h000000, byte_sel}
                                           : {{24{byte_sel[7]}}, byte_sel};
            SIZE_HALF: data_o = unsigned_i ? {16'h0000, half_sel}
                                           : {{16{half_sel[15]}}, half_sel};
            default:   data_o = word_i;
        endcase
    end

endmodule

// File: rtl/riscv_cache.sv
// Unified instruction/data word memory: loaded over the I/O port while invalid,
// then serves fetch and byte/half/word loads/stores. Optional: CACHE_BOUNDS_CHECK_EN.
module riscv_cache
    import riscv_cache_pkg::*;
#(
    parameter int DEPTH = 8192,
    parameter int IDX_W = 13
) (
    input  logic        ip_clk,
    input  logic        ip_rst,
    input  logic [31:0] ip_wr_addr,
    input  logic [31:0] ip_wr_data,
    input  logic        ip_wr_en,
    input  logic        ip_wr_done_ctrl,
    input  logic [31:0] ip_pc,
    input  logic [31:0] ip_load_store_addr,
    input  logic [31:0] ip_store_data,
    input  logic [1:0]  ip_load_store_bit_ctrl,
    input  logic        ip_load_sign_ctrl,
    input  logic        ip_store_en,
    input  logic        ip_done_execute_ctrl,
    output logic [31:0] op_instr,
    output logic [31:0] op_data,
    output logic        op_valid_ctrl
);

    cache_state_e state_q;
    logic         valid_q;

    logic [31:0] mem_q [DEPTH];

    logic [IDX_W-1:0] pc_idx;
    logic [IDX_W-1:0] io_idx;
    logic [IDX_W-1:0] ls_idx;
    logic             pc_ok;
    logic             io_ok;
    logic             ls_ok;

    logic             wr_fire_d;
    logic [IDX_W-1:0] wr_idx_d;
    logic [3:0]       wr_be_d;
    logic [31:0]      wr_word_d;

    logic [31:0] load_word;
    logic [31:0] load_aligned;

    // Valid flag: done_execute wins in VALID, wr_done wins in INVALID.
    always_ff @(posedge ip_clk or negedge ip_rst) begin
        if (!ip_rst) begin
            state_q <= ST_INVALID;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INVALID: begin
                    if (ip_wr_done_ctrl) begin
                        state_q <= ST_VALID;
                        valid_q <= 1'b1;
                    end
                end
                default: begin
                    if (ip_done_execute_ctrl) begin
                        state_q <= ST_INVALID;
                        valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign op_valid_ctrl = valid_q;

    assign pc_idx = ip_pc[IDX_W+1:2];
    assign io_idx = ip_wr_addr[IDX_W+1:2];
    assign ls_idx = ip_load_store_addr[IDX_W+1:2];

`ifdef CACHE_BOUNDS_CHECK_EN
    assign pc_ok = (ip_pc >> (IDX_W + 2)) == 32'd0;
    assign io_ok = (ip_wr_addr >> (IDX_W + 2)) == 32'd0;
    assign ls_ok = (ip_load_store_addr >> (IDX_W + 2)) == 32'd0;
`else
    assign pc_ok = 1'b1;
    assign io_ok = 1'b1;
    assign ls_ok = 1'b1;
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = ^{ip_pc[1:0], ip_wr_addr[1:0],
                                ip_pc[31:IDX_W+2], ip_wr_addr[31:IDX_W+2],
                                ip_load_store_addr[31:IDX_W+2]};

    // One write port: I/O loads only while invalid, stores only while valid.
    always_comb begin
        wr_fire_d = 1'b0;
        wr_idx_d  = io_idx;
        wr_be_d   = 4'b0000;
        wr_word_d = ip_wr_data;
        if (ip_rst) begin
            if (!valid_q) begin
                wr_fire_d = ip_wr_en && io_ok;
                wr_idx_d  = io_idx;
                wr_be_d   = 4'b1111;
                wr_word_d = ip_wr_data;
            end else begin
                wr_fire_d = ip_store_en && ls_ok;
                wr_idx_d  = ls_idx;
                wr_be_d   = store_byte_en(ip_load_store_bit_ctrl, ip_load_store_addr[1:0]);
                case (ip_load_store_bit_ctrl)
                    SIZE_BYTE: wr_word_d = {4{ip_store_data[7:0]}};
                    SIZE_HALF: wr_word_d = {2{ip_store_data[15:0]}};
                    default:   wr_word_d = ip_store_data;
                endcase
            end
        end
    end

    // Contents are deliberately not reset; they survive reset and done_execute.
    always_ff @(posedge ip_clk) begin
        if (wr_fire_d) begin
            for (int l = 0; l < 4; l++) begin
                if (wr_be_d[l]) begin
                    mem_q[wr_idx_d][8*l +: 8] <= wr_word_d[8*l +: 8];
                end
            end
        end
    end

    assign load_word = mem_q[ls_idx];

    riscv_cache_load_align u_load_align (
        .word_i     (load_word),
        .off_i      (ip_load_store_addr[1:0]),
        .size_i     (ip_load_store_bit_ctrl),
        .unsigned_i (ip_load_sign_ctrl),
        .data_o     (load_aligned)
    );

    assign op_instr = (valid_q && pc_ok) ? mem_q[pc_idx] : 32'h0000_0000;
    assign op_data  = (valid_q && !ip_store_en && ls_ok) ? load_aligned : 32'h0000_0000;

endmodule

// File: tb/tb_riscv_cache.sv
// Directed self-checking bench for riscv_cache: I/O load, fetch, sized
// loads/stores, valid-flag transitions and asynchronous reset.
module tb_riscv_cache;
    import riscv_cache_pkg::*;

    logic        ip_clk;
    logic        ip_rst;
    logic [31:0] ip_wr_addr;
    logic [31:0] ip_wr_data;
    logic        ip_wr_en;
    logic        ip_wr_done_ctrl;
    logic [31:0] ip_pc;
    logic [31:0] ip_load_store_addr;
    logic [31:0] ip_store_data;
    logic [1:0]  ip_load_store_bit_ctrl;
    logic        ip_load_sign_ctrl;
    logic        ip_store_en;
    logic        ip_done_execute_ctrl;
    logic [31:0] op_instr;
    logic [31:0] op_data;
    logic        op_valid_ctrl;

    int n_cmp;
    int n_err;

    riscv_cache dut (
        .ip_clk                 (ip_clk),
        .ip_rst                 (ip_rst),
        .ip_wr_addr             (ip_wr_addr),
        .ip_wr_data             (ip_wr_data),
        .ip_wr_en               (ip_wr_en),
        .ip_wr_done_ctrl        (ip_wr_done_ctrl),
        .ip_pc                  (ip_pc),
        .ip_load_store_addr     (ip_load_store_addr),
        .ip_store_data          (ip_store_data),
        .ip_load_store_bit_ctrl (ip_load_store_bit_ctrl),
        .ip_load_sign_ctrl      (ip_load_sign_ctrl),
        .ip_store_en            (ip_store_en),
        .ip_done_execute_ctrl   (ip_done_execute_ctrl),
        .op_instr               (op_instr),
        .op_data                (op_data),
        .op_valid_ctrl          (op_valid_ctrl)
    );

    // Clock and reset
    initial begin
        ip_clk = 1'b0;
        forever #(PERIOD_HALF) ip_clk = ~ip_clk;
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge ip_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic io_write(input logic [31:0] addr, input logic [31:0] data, input logic done);
        ip_wr_addr      = addr;
        ip_wr_data      = data;
        ip_wr_en        = 1'b1;
        ip_wr_done_ctrl = done;
        tick();
        ip_wr_en        = 1'b0;
        ip_wr_done_ctrl = 1'b0;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        ip_load_store_addr     = addr;
        ip_store_data          = data;
        ip_load_store_bit_ctrl = size;
        ip_store_en            = 1'b1;
        tick();
        ip_store_en = 1'b0;
    endtask

    task automatic load_check(input string tag, input logic [31:0] addr, input logic [1:0] size,
                              input logic uns, input logic [31:0] exp);
        ip_load_store_addr     = addr;
        ip_load_store_bit_ctrl = size;
        ip_load_sign_ctrl      = uns;
        ip_store_en            = 1'b0;
        #1;
        check(tag, op_data, exp);
    endtask

    task automatic fetch_check(input string tag, input logic [31:0] pc, input logic [31:0] exp);
        ip_pc = pc;
        #1;
        check(tag, op_instr, exp);
    endtask

    // Directed stimulus
    initial begin
        n_cmp = 0;
        n_err = 0;
        ip_rst                 = 1'b0;
        ip_wr_addr             = '0;
        ip_wr_data             = '0;
        ip_wr_en               = 1'b0;
        ip_wr_done_ctrl        = 1'b0;
        ip_pc                  = '0;
        ip_load_store_addr     = '0;
        ip_store_data          = '0;
        ip_load_store_bit_ctrl = SIZE_WORD;
        ip_load_sign_ctrl      = 1'b0;
        ip_store_en            = 1'b0;
        ip_done_execute_ctrl   = 1'b0;

        tick();
        tick();
        check("reset_valid", {31'd0, op_valid_ctrl}, 32'd0);
        check("reset_instr", op_instr, 32'd0);
        check("reset_data", op_data, 32'd0);
        ip_rst = 1'b1;
        tick();

        io_write(32'h0, 32'h0002A303, 1'b0);
        io_write(32'h4, 32'h020002B7, 1'b0);
        io_write(32'h8, 32'h0002A303, 1'b0);
        check("valid_before_done", {31'd0, op_valid_ctrl}, 32'd0);
        io_write(32'hC, 32'h0042A383, 1'b1);
        check("valid_after_done", {31'd0, op_valid_ctrl}, 32'd1);
        fetch_check("fetch_0", 32'h0, 32'h0002A303);
        fetch_check("fetch_4", 32'h4, 32'h020002B7);
        fetch_check("fetch_8", 32'h8, 32'h0002A303);
        fetch_check("fetch_c_unaligned", 32'hF, 32'h0042A383);

        // I/O write while valid must be ignored.
        io_write(32'h0, 32'hFFFFFFFF, 1'b0);
        fetch_check("io_write_ignored", 32'h0, 32'h0002A303);

        store(32'h4000, 32'h08EF965D, SIZE_BYTE);
        load_check("lb_4000", 32'h4000, SIZE_BYTE, 1'b0, 32'h0000005D);
        store(32'h4004, 32'hD9A438B8, SIZE_BYTE);
        load_check("lbu_4004", 32'h4004, SIZE_BYTE, 1'b1, 32'h000000B8);
        load_check("lb_4004", 32'h4004, SIZE_BYTE, 1'b0, 32'hFFFFFFB8);

        store(32'h4008, 32'h5ED7C51F, SIZE_HALF);
        load_check("lh_4008", 32'h4008, SIZE_HALF, 1'b0, 32'hFFFFC51F);
        store(32'h400C, 32'h050B925A, SIZE_HALF);
        load_check("lhu_400c", 32'h400C, SIZE_HALF, 1'b1, 32'h0000925A);

        store(32'h4010, 32'h12345678, SIZE_WORD);
        store(32'h4014, 32'h87654321, SIZE_WORD);
        load_check("lw_4010", 32'h4010, SIZE_WORD, 1'b0, 32'h12345678);
        load_check("lw_4014", 32'h4014, SIZE_WORD, 1'b0, 32'h87654321);
        store(32'h4013, 32'h000000AA, SIZE_BYTE);
        load_check("lw_4010_after_sb", 32'h4010, SIZE_WORD, 1'b0, 32'hAA345678);

        // Upper halfword store, then loads of that half and its top byte.
        store(32'h4016, 32'h0000BEEF, SIZE_HALF);
        load_check("lw_4014_after_sh", 32'h4014, SIZE_WORD, 1'b0, 32'hBEEF4321);
        load_check("lh_4016", 32'h4016, SIZE_HALF, 1'b0, 32'hFFFFBEEF);
        load_check("lb_4017", 32'h4017, SIZE_BYTE, 1'b0, 32'hFFFFFFBE);
        load_check("lbu_4015", 32'h4015, SIZE_BYTE, 1'b1, 32'h00000043);
        load_check("size11_word", 32'h4014, 2'b11, 1'b0, 32'hBEEF4321);
        // Word store ignores addr[1:0].
        store(32'h4022, 32'hCAFEF00D, SIZE_WORD);
        load_check("lw_4020_sw_unaligned", 32'h4020, SIZE_WORD, 1'b0, 32'hCAFEF00D);
`ifdef CACHE_BOUNDS_CHECK_EN
        load_check("lw_out_of_range", 32'hC010, SIZE_WORD, 1'b0, 32'h00000000);
`else
        load_check("lw_wrap", 32'hC010, SIZE_WORD, 1'b0, 32'hAA345678);
`endif

        // op_data is zero while a store is being presented.
        ip_load_store_addr     = 32'h4010;
        ip_load_store_bit_ctrl = SIZE_WORD;
        ip_store_en            = 1'b1;
        ip_store_data          = 32'hAA345678;
        #1;
        check("data_zero_during_store", op_data, 32'd0);
        tick();
        ip_store_en = 1'b0;

        ip_done_execute_ctrl = 1'b1;
        tick();
        ip_done_execute_ctrl = 1'b0;
        check("valid_after_exec_done", {31'd0, op_valid_ctrl}, 32'd0);
        fetch_check("instr_zero_invalid", 32'h0, 32'd0);
        load_check("data_zero_invalid", 32'h4010, SIZE_WORD, 1'b0, 32'd0);

        store(32'h4010, 32'hDEADBEEF, SIZE_WORD);
        io_write(32'h20, 32'h11111111, 1'b1);
        check("valid_reload", {31'd0, op_valid_ctrl}, 32'd1);
        fetch_check("write_with_done", 32'h20, 32'h11111111);
        load_check("store_while_invalid_dropped", 32'h4010, SIZE_WORD, 1'b0, 32'hAA345678);

        // Both controls high: VALID -> INVALID, then INVALID -> VALID.
        ip_wr_done_ctrl      = 1'b1;
        ip_done_execute_ctrl = 1'b1;
        tick();
        check("both_high_in_valid", {31'd0, op_valid_ctrl}, 32'd0);
        tick();
        check("both_high_in_invalid", {31'd0, op_valid_ctrl}, 32'd1);
        ip_wr_done_ctrl      = 1'b0;
        ip_done_execute_ctrl = 1'b0;

        store(32'h4010, 32'h12345678, SIZE_WORD);
        load_check("lw_4010_restore", 32'h4010, SIZE_WORD, 1'b0, 32'h12345678);

        // Asynchronous reset between edges.
        #2;
        ip_rst = 1'b0;
        #1;
        check("async_reset_valid", {31'd0, op_valid_ctrl}, 32'd0);
        fetch_check("async_reset_instr", 32'h0, 32'd0);
        tick();
        #2;
        ip_rst = 1'b1;
        tick();
        io_write(32'h24, 32'h00000013, 1'b1);
        check("valid_after_reset_reload", {31'd0, op_valid_ctrl}, 32'd1);
        load_check("mem_retained_after_reset", 32'h4010, SIZE_WORD, 1'b0, 32'h12345678);
        fetch_check("fetch_retained_after_reset", 32'h4, 32'h020002B7);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
